// File: rtl/tff_pkg.sv
// Shared constants and helpers for the toggle-cell modulo counter.
package tff_pkg;

  // Direction encoding for the up input.
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Saturate a load value at the highest legal count.
  function automatic int unsigned clamp_max(input int unsigned value, input int unsigned max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single-bit toggle storage cell: q flips on a rising edge when t is high.
module tff_cell (
  input  logic clc,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  // Toggle register with asynchronous clear.
  always_ff @(posedge clc or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo up/down counter whose state lives entirely in toggle cells. The toggle
// vector is exported so external toggle stages can track the count in lockstep.
module tff_mod_counter
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 2 ** WIDTH - 1
) (
  input  logic             clc,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] d;

  // Next-state target in priority order clear > load > count > hold.
  always_comb begin
    d = q;
    if (clr) begin
      d = '0;
    end else if (load) begin
      d = WIDTH'(clamp_max(32'(load_val), MAX));
    end else if (en) begin
      case (up)
        DIR_UP:  d = (q == MaxVal) ? '0 : q + One;
        DIR_DN:  d = (q == '0) ? MaxVal : q - One;
        default: d = q;
      endcase
    end
  end

  // Toggle enables and terminal count; load/clear mask the wrap indication.
  always_comb begin
    t_vec = q ^ d;
    tc    = en & ~clr & ~load & ((up == DIR_UP) ? (q == MaxVal) : (q == '0));
  end

  // State storage: one toggle cell per bit, driven only by t_vec.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clc   (clc),
      .rst_n (rst_n),
      .t     (t_vec[i]),
      .q     (q[i])
    );
  end

  // Wrap pulse: registered copy of tc, high for the cycle after a wrap step.
  always_ff @(posedge clc or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

endmodule

// File: tb/tb_tff_mod_counter.sv
module tb_tff_mod_counter;

  localparam int W = 4;
  localparam int M = 9;

  logic         clc = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic [W-1:0] q;
  logic [W-1:0] t_vec;
  logic         tc;
  logic         wrap;

  tff_mod_counter #(.WIDTH(W), .MAX(M)) dut (
    .clc      (clc),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up       (up),
    .q        (q),
    .t_vec    (t_vec),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clc = ~clc;

  typedef struct {
    int unsigned q;
    bit          wrap;
    bit          tc;
    int unsigned t_vec;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   total = 0;
  int   bad = 0;
  int   step_id = 0;

  // Reference model state: count as a plain integer in 0..M.
  int unsigned m_q = 0;
  bit          m_wrap = 0;
  int unsigned m_d = 0;
  bit          m_tc = 0;

  function automatic void model_eval();
    if (!rst_n) begin
      m_q = 0;
      m_wrap = 0;
    end
    if (clr)       m_d = 0;
    else if (load) m_d = (int'(load_val) > M) ? M : load_val;
    else if (en)   m_d = up ? (m_q + 1) % (M + 1) : (m_q + M) % (M + 1);
    else           m_d = m_q;
    m_tc = en && !clr && !load && (up ? (m_q == M) : (m_q == 0));
  endfunction

  function automatic void push_expect();
    exp_t e;
    e.q = m_q;
    e.wrap = m_wrap;
    e.tc = m_tc;
    e.t_vec = (m_q ^ m_d) & ((1 << W) - 1);
    e.id = step_id;
    exp_q.push_back(e);
  endfunction

  // One clock cycle: drive at negedge, record expectation, advance model at posedge.
  task automatic step(input bit r, input bit c, input bit l, input int lv, input bit e,
                      input bit u);
    @(negedge clc);
    rst_n = r;
    clr = c;
    load = l;
    load_val = W'(lv);
    en = e;
    up = u;
    step_id++;
    model_eval();
    push_expect();
    ->chk_ev;
    if (rst_n) begin
      m_wrap = m_tc;
      m_q = m_d;
    end
  endtask

  // Monitor: pop the oldest expectation and compare against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      if (exp_q.size() == 0) begin
        bad++;
        total++;
        $display("FAIL scoreboard empty at step %0d", step_id);
      end else begin
        e = exp_q.pop_front();
        total += 4;
        if (int'(q) != e.q) begin
          bad++;
          $display("FAIL q step %0d: got %0d want %0d", e.id, q, e.q);
        end
        if (wrap != e.wrap) begin
          bad++;
          $display("FAIL wrap step %0d: got %0b want %0b", e.id, wrap, e.wrap);
        end
        if (tc != e.tc) begin
          bad++;
          $display("FAIL tc step %0d: got %0b want %0b", e.id, tc, e.tc);
        end
        if (int'(t_vec) != e.t_vec) begin
          bad++;
          $display("FAIL t_vec step %0d: got %b want %b", e.id, t_vec, W'(e.t_vec));
        end
      end
    end
  end

  initial begin
    // Reset held with counting enabled, then release.
    repeat (3) step(0, 0, 0, 0, 1, 1);
    repeat (2) step(1, 0, 0, 0, 1, 1);
    // Up wrap 8 -> 9 -> 0 -> 1.
    step(1, 0, 1, 8, 0, 1);
    repeat (4) step(1, 0, 0, 0, 1, 1);
    // Down wrap from 0.
    step(1, 1, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 1, 0);
    // Load clamp, then clear beats load.
    step(1, 0, 1, 13, 0, 1);
    step(1, 1, 1, 5, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    // Load beats a pending wrap.
    step(1, 0, 1, 9, 0, 1);
    step(1, 0, 1, 3, 1, 1);
    step(1, 0, 0, 0, 0, 1);
    // Hold at 6.
    step(1, 0, 1, 6, 0, 1);
    repeat (5) step(1, 0, 0, 0, 0, 1);
    // Asynchronous reset asserted mid-cycle.
    repeat (3) step(1, 0, 0, 0, 1, 1);
    @(posedge clc);
    #3;
    rst_n = 0;
    step_id++;
    model_eval();
    push_expect();
    ->chk_ev;
    #2;
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 0);
    // Randomized traffic with rare resets and a bias toward counting.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 15),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1));
    end
    @(negedge clc);
    #3;
    if (exp_q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tff_mod_counter.md
# tff_mod_counter

Synchronous modulo up/down counter built from T-type storage cells. Each cycle it computes a per-bit toggle-enable vector (t_vec) that drives its own internal toggle cells; the vector is also exported so external toggle flip-flop stages can be driven in lockstep. It sits directly upstream of the toggle flip-flop stages. It converts count/load/clear commands into toggle enables, and provides terminal-count and wrap indications to downstream control.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥ 2)
- MAX, 2**WIDTH-1, highest count value; the counter counts 0..MAX inclusive (1 ≤ MAX ≤ 2**WIDTH-1)

Ports:
- clc  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous reset, active-low
- clr  input  1  synchronous clear to 0
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value to load
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- q  output  WIDTH  current count (registered)
- t_vec  output  WIDTH  toggle enables applied at the next rising edge (combinational)
- tc  output  1  terminal count: the next count step wraps (combinational)
- wrap  output  1  one-cycle pulse, registered, after a wrap step

Clocking and reset:
- One clock (clc).
- Reset is asynchronous and active-low (rst_n).

## Operation
- Next-state target d, evaluated in priority order:
  - clr = 1: d = 0.
  - else load = 1: d = min(load_val, MAX), so out-of-range loads clamp to MAX.
  - else en = 1 and up = 1: d = (q == MAX) ? 0 : q+1.
  - else en = 1 and up = 0: d = (q == 0) ? MAX : q-1.
  - else d = q.
- t_vec = q XOR d. This is the only path into state: bit i of q toggles at the edge iff t_vec[i] = 1.
- With no command active, t_vec = 0.
- tc = en & ~clr & ~load & (up ? q == MAX : q == 0).
- wrap is registered: it is set to tc at each edge, so it is high for exactly the cycle after the wrap step.
- clr and load suppress tc and therefore wrap, even when q is at a boundary.
- Arithmetic is unsigned and WIDTH bits wide.
- States above MAX are unreachable: reset gives 0, load clamps, and counting wraps at MAX.

## Timing
- Asynchronous reset (rst_n low):
  - q = 0 and wrap = 0 immediately, independent of clc.
  - t_vec and tc follow combinationally from q = 0 and the current inputs.
- Latency:
  - Command to q change: 1 edge.
  - Wrap step to wrap pulse: 1 edge.
  - tc is valid in the same cycle as the command.
- Reset released mid-count: counting resumes from 0 on the first edge after rst_n rises; no spurious wrap.
- rst_n asserted mid-cycle: all state is discarded at once and no partial toggle is committed.
- Simultaneous events:
  - clr + load: clear wins.
  - load + en: load wins, and no wrap.
  - up changing every cycle is legal; each edge uses the up value sampled at that edge.
- MAX = 2**WIDTH-1 gives natural binary wrap. Other MAX values give a truncated modulus with an explicit wrap to 0 or MAX.

## Structure
- Sub-module tff_cell: a single-bit toggle cell.
  - Ports: clc, rst_n, t, q.
  - Async active-low reset to 0; q <= q ^ t on the rising edge.
  - Instantiate WIDTH copies with a generate loop.
- Shared package tff_pkg holds:
  - direction constants DIR_UP = 1 and DIR_DN = 0;
  - the function clamp_max(value, max) used for the load clamp.
- Next-state and t_vec logic stay in tff_mod_counter. No other sub-modules.

## Test plan
All scenarios use WIDTH = 4, MAX = 9.
- Reset: hold rst_n = 0 with en = 1 for 3 edges -> q = 0 and wrap = 0 throughout. Release rst_n -> q = 1 after the first edge.
- Up wrap: load 8, then en = 1, up = 1:
  - q = 8 -> 9 -> 0 -> 1;
  - tc = 1 while q = 9;
  - wrap = 1 only in the cycle where q = 0;
  - t_vec = 4'b1001 when q = 9.
- Down wrap: from q = 0 with en = 1, up = 0 -> q = 9 -> 8; tc = 1 at q = 0; wrap pulses once.
- Load clamp and priority:
  - load_val = 13 -> q = 9.
  - Next cycle, clr = 1 and load = 1 with load_val = 5 -> q = 0, wrap = 0.
- Load over wrap: q = 9, en = 1, up = 1, load = 1, load_val = 3 -> q = 3, tc = 0, wrap = 0.
- Hold: en = 0, clr = 0, load = 0 for 5 cycles at q = 6 -> q stays 6, t_vec = 0, tc = 0.
